// File: rtl/rv32i_types.sv
// Shared types for the eviction write-back buffer: the controller state encoding.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    PMEM_READ,
    PMEM_WRITE
  } ewb_state_t;

endpackage

// File: rtl/ewb_match.sv
// Associative lookup over the buffered lines: reports a hit and the index of the
// youngest matching entry, searching backwards from the slot just behind tail.
module ewb_match
  import rv32i_types::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [ADDR_W-1:0] query_i,
  input  logic [PTR_W-1:0]  tail_i,
  output logic              hit_o,
  output logic [PTR_W-1:0]  idx_o
);

  // Walk oldest to youngest so the last assignment is the youngest match;
  // an offset of DEPTH wraps back onto tail itself, the oldest slot when full.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_i[tail_i - PTR_W'(k)] && (addr_i[tail_i - PTR_W'(k)] == query_i)) begin
        hit_o = 1'b1;
        idx_o = tail_i - PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/ewb_fifo.sv
// Eviction write-back buffer: queues dirty lines from the cache, drains them to
// memory in order, coalesces rewrites and serves reads from buffered lines.
module ewb_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      up_address,
  input  logic [LINE_W-1:0]      up_wdata,
  input  logic                   up_read,
  input  logic                   up_write,
  output logic [LINE_W-1:0]      up_rdata,
  output logic                   up_resp,
  output logic [ADDR_W-1:0]      pmem_address,
  output logic [LINE_W-1:0]      pmem_wdata,
  input  logic [LINE_W-1:0]      pmem_rdata,
  output logic                   pmem_read,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ewb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];

  logic [DEPTH-1:0]  match_mask;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              is_empty, is_full, push, pop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // A write must not coalesce into the head while it is on the memory bus.
  always_comb begin
    match_mask = valid_q;
    if (up_write && (state_q == PMEM_WRITE)) match_mask[head_q] = 1'b0;
  end

  ewb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match (
    .valid_i (match_mask),
    .addr_i  (addr_q),
    .query_i (up_address),
    .tail_i  (tail_q),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    data_d       = data_q;
    up_resp      = 1'b0;
    up_rdata     = pmem_rdata;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = addr_q[head_q];
    pmem_wdata   = data_q[head_q];
    push         = 1'b0;
    pop          = 1'b0;

    if (up_write) begin
      if (hit) begin
        data_d[hit_idx] = up_wdata;
        up_resp         = 1'b1;
      end else if (!is_full) begin
        push            = 1'b1;
        valid_d[tail_q] = 1'b1;
        addr_d[tail_q]  = up_address;
        data_d[tail_q]  = up_wdata;
        tail_d          = tail_q + 1'b1;
        up_resp         = 1'b1;
      end
    end else if (up_read && hit) begin
      up_resp  = 1'b1;
      up_rdata = data_q[hit_idx];
    end

    unique case (state_q)
      IDLE: begin
        if (up_read && !hit)  state_d = PMEM_READ;
        else if (!is_empty)   state_d = PMEM_WRITE;
      end
      PMEM_READ: begin
        pmem_read    = 1'b1;
        pmem_address = up_address;
        if (up_read && !hit) up_resp = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      PMEM_WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          pop             = 1'b1;
          valid_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Outputs are forced quiet while reset is held, before the first edge lands.
    if (!reset_n) begin
      up_resp    = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Line storage carries no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign count = count_q;
  assign empty = !reset_n || is_empty;
  assign full  = reset_n && is_full;

endmodule

// File: tb/tb_ewb_fifo.sv
// Self-checking bench for ewb_fifo: directed scenarios plus a transaction-level
// scoreboard of buffered lines checked against every drain and read hit.
module tb_ewb_fifo;

  localparam int DEPTH  = 4;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] up_address;
  logic [LINE_W-1:0] up_wdata;
  logic              up_read, up_write;
  logic [LINE_W-1:0] up_rdata;
  logic              up_resp;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [2:0]        count;
  logic              empty, full;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } ent_t;

  ent_t              mq[$];
  logic [ADDR_W-1:0] dl_addr[$];
  logic [LINE_W-1:0] dl_data[$];
  int                mk;

  ewb_fifo #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .up_address   (up_address),
    .up_wdata     (up_wdata),
    .up_read      (up_read),
    .up_write     (up_write),
    .up_rdata     (up_rdata),
    .up_resp      (up_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] mkd(input logic [31:0] s);
    return {8{s}};
  endfunction

  always @(posedge clk) begin
    if (reset_n) assert (!(up_read && up_write)) else $error("illegal: up_read and up_write together");
  end

  // Scoreboard: accepted writes update the model, drains and read hits are checked against it.
  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
    end else begin
      if (pmem_read || pmem_write) begin
        n_chk++;
        if ((pmem_read && pmem_write) !== 1'b0) begin
          n_fail++;
          $display("FAIL pmem_excl: pmem_read=%0b pmem_write=%0b, required not both", pmem_read, pmem_write);
        end
      end
      if (up_write && up_resp) begin
        mk = -1;
        for (int i = mq.size() - 1; i >= 0; i--)
          if (mk < 0 && mq[i].addr == up_address && !(i == 0 && pmem_write)) mk = i;
        if (mk >= 0) mq[mk].data = up_wdata;
        else mq.push_back('{up_address, up_wdata});
      end
      if (up_read && up_resp && !pmem_read) begin
        mk = -1;
        for (int i = mq.size() - 1; i >= 0; i--)
          if (mk < 0 && mq[i].addr == up_address) mk = i;
        n_chk++;
        if (mk < 0) begin
          n_fail++;
          $display("FAIL sb_read_hit: DUT hit on %h, model holds no such line", up_address);
        end else if (up_rdata !== mq[mk].data) begin
          n_fail++;
          $display("FAIL sb_read_data: got %h required %h", up_rdata, mq[mk].data);
        end
      end
      if (pmem_write && pmem_resp) begin
        dl_addr.push_back(pmem_address);
        dl_data.push_back(pmem_wdata);
        n_chk++;
        if (mq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_drain: drained %h with model empty", pmem_address);
        end else begin
          if ({pmem_address, pmem_wdata} !== {mq[0].addr, mq[0].data}) begin
            n_fail++;
            $display("FAIL sb_drain: got %h/%h required %h/%h", pmem_address, pmem_wdata, mq[0].addr, mq[0].data);
          end
          void'(mq.pop_front());
        end
      end
    end
  end

  task automatic wait_pmem_write(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (pmem_write) ok = 1'b1;
    end
  endtask

  task automatic write_line(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    @(posedge clk); #1;
    up_address = a;
    up_wdata   = d;
    up_write   = 1'b1;
  endtask

  task automatic release_up();
    @(posedge clk); #1;
    up_write = 1'b0;
    up_read  = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (empty) done = 1'b1;
      else if (pmem_write) begin
        @(posedge clk); #1; pmem_resp = 1'b1;
        @(posedge clk); #1; pmem_resp = 1'b0;
      end
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: empty=%0b required 1", tag, empty);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; up_read = 1'b0; up_write = 1'b0; pmem_resp = 1'b0;
    up_address = '0; up_wdata = '0; pmem_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if ({pmem_read, pmem_write, up_resp} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b required 000", {pmem_read, pmem_write, up_resp}); end
    n_chk++; if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL rst_flags: empty/full got %b required 10", {empty, full}); end
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", count); end
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    bit ok;
    dl_addr.delete(); dl_data.delete();
    write_line(32'h100, mkd(32'hD1));
    @(negedge clk);
    n_chk++; if (up_resp !== 1'b1) begin n_fail++; $display("FAIL wr1_resp: got %b required 1", up_resp); end
    release_up();
    @(negedge clk);
    n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL wr1_count: got %0d required 1", count); end
    wait_pmem_write(ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr1_pmem_write: got no pmem_write, required one"); end
    n_chk++; if (pmem_address !== 32'h100) begin n_fail++; $display("FAIL wr1_addr: got %h required 00000100", pmem_address); end
    @(posedge clk); #1; pmem_resp = 1'b1;
    @(posedge clk); #1; pmem_resp = 1'b0;
    @(negedge clk);
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wr1_empty: got %b required 1", empty); end
    n_chk++; if ((dl_data.size() == 1 ? dl_data[0] : '0) !== mkd(32'hD1)) begin n_fail++; $display("FAIL wr1_drain_data: %0d drains, required one with D1", dl_data.size()); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      write_line(32'h1000 + 32'(i) * 32'h40, mkd(32'hF0 + 32'(i)));
      @(negedge clk);
      n_chk++; if (up_resp !== 1'b1) begin n_fail++; $display("FAIL full_fill_resp%0d: got %b required 1", i, up_resp); end
    end
    write_line(32'h5000, mkd(32'hF5));
    @(negedge clk);
    n_chk++; if ({count, full} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL full_flag: count=%0d full=%b required 4/1", count, full); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++; if (up_resp !== 1'b0) begin n_fail++; $display("FAIL full_stall%0d: up_resp got %b required 0", i, up_resp); end
    end
    @(posedge clk); #1; pmem_resp = 1'b1;
    @(negedge clk);
    n_chk++; if (up_resp !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle: up_resp got %b required 0", up_resp); end
    @(posedge clk); #1; pmem_resp = 1'b0;
    @(negedge clk);
    n_chk++; if ({count, up_resp} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL full_accept: count=%0d up_resp=%b required 3/1", count, up_resp); end
    release_up();
    @(negedge clk);
    n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count_after: got %0d required 4", count); end
    drain_all("full");
  endtask

  task automatic test_coalesce();
    bit ok;
    dl_addr.delete(); dl_data.delete();
    write_line(32'h1F0, mkd(32'hA0));
    release_up();
    wait_pmem_write(ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coal_drain_start: got no pmem_write, required one"); end
    write_line(32'h200, mkd(32'hD2));
    @(negedge clk);
    @(posedge clk); #1; up_wdata = mkd(32'hD3);
    @(negedge clk);
    n_chk++; if ({up_resp, count} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL coal_resp: up_resp=%b count=%0d required 1/2", up_resp, count); end
    @(posedge clk); #1; up_address = 32'h1F0; up_wdata = mkd(32'hA1);
    @(negedge clk);
    n_chk++; if ({up_resp, count} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL coal_head_resp: up_resp=%b count=%0d required 1/2", up_resp, count); end
    release_up();
    @(negedge clk);
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL coal_head_push: count got %0d required 3", count); end
    drain_all("coal");
    n_chk++; if ((dl_data.size() == 3 ? dl_data[1] : '0) !== mkd(32'hD3)) begin n_fail++; $display("FAIL coal_d3: %0d drains, second not D3", dl_data.size()); end
    n_chk++; if ((dl_data.size() == 3 ? dl_data[2] : '0) !== mkd(32'hA1)) begin n_fail++; $display("FAIL coal_head_new: %0d drains, third not A1", dl_data.size()); end
  endtask

  task automatic test_read_hit();
    bit ok;
    write_line(32'h300, mkd(32'hD4));
    release_up();
    wait_pmem_write(ok);
    @(posedge clk); #1; up_address = 32'h300; up_read = 1'b1;
    @(negedge clk);
    n_chk++; if ({up_resp, pmem_read} !== 2'b10) begin n_fail++; $display("FAIL rd_hit_resp: up_resp/pmem_read got %b required 10", {up_resp, pmem_read}); end
    n_chk++; if (up_rdata !== mkd(32'hD4)) begin n_fail++; $display("FAIL rd_hit_data: got %h required D4", up_rdata); end
    @(posedge clk); #1; up_read = 1'b0; up_write = 1'b1; up_wdata = mkd(32'hD5);
    @(negedge clk);
    @(posedge clk); #1; up_write = 1'b0; up_read = 1'b1;
    @(negedge clk);
    n_chk++; if ({up_resp, up_rdata} !== {1'b1, mkd(32'hD5)}) begin n_fail++; $display("FAIL rd_youngest: resp=%b data=%h required 1/D5", up_resp, up_rdata); end
    release_up();
    @(negedge clk);
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL rd_hit_no_pmem: pmem_read got %b required 0", pmem_read); end
    drain_all("rdhit");
  endtask

  task automatic test_read_miss();
    bit ok;
    write_line(32'h380, mkd(32'hD6));
    release_up();
    wait_pmem_write(ok);
    @(posedge clk); #1; up_address = 32'h400; up_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if ({pmem_read, up_resp, pmem_write} !== 3'b001) begin n_fail++; $display("FAIL miss_wait%0d: read/resp/write got %b required 001", i, {pmem_read, up_resp, pmem_write}); end
    end
    @(posedge clk); #1; pmem_resp = 1'b1;
    @(posedge clk); #1; pmem_resp = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (pmem_read) ok = 1'b1;
    end
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL miss_pmem_read: got no pmem_read, required one"); end
    n_chk++; if ({pmem_address, pmem_write} !== {32'h400, 1'b0}) begin n_fail++; $display("FAIL miss_addr: got %h/%b required 00000400/0", pmem_address, pmem_write); end
    @(posedge clk); #1; pmem_rdata = mkd(32'hE1); pmem_resp = 1'b1;
    @(negedge clk);
    n_chk++; if ({up_resp, up_rdata} !== {1'b1, mkd(32'hE1)}) begin n_fail++; $display("FAIL miss_data: resp=%b data=%h required 1/E1", up_resp, up_rdata); end
    @(posedge clk); #1; pmem_resp = 1'b0; up_read = 1'b0;
    @(negedge clk);
    n_chk++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL miss_done: pmem_read got %b required 0", pmem_read); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    dl_addr.delete(); dl_data.delete();
    write_line(32'h700, mkd(32'hB0));
    release_up();
    wait_pmem_write(ok);
    @(posedge clk); #1; up_address = 32'h740; up_wdata = mkd(32'hB1); up_write = 1'b1; pmem_resp = 1'b1;
    @(negedge clk);
    n_chk++; if ({up_resp, pmem_write} !== 2'b11) begin n_fail++; $display("FAIL b2b_resp: up_resp/pmem_write got %b required 11", {up_resp, pmem_write}); end
    @(posedge clk); #1; up_write = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count: got %0d required 1", count); end
    drain_all("b2b");
    n_chk++; if ((dl_addr.size() == 2 ? dl_addr[1] : '0) !== 32'h740) begin n_fail++; $display("FAIL b2b_order: %0d drains, second not 740", dl_addr.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    write_line(32'h500, mkd(32'hC0));
    @(negedge clk);
    @(posedge clk); #1; up_address = 32'h540; up_wdata = mkd(32'hC1);
    release_up();
    wait_pmem_write(ok);
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({pmem_write, up_resp} !== 2'b00) begin n_fail++; $display("FAIL rstmid_during: write/resp got %b required 00", {pmem_write, up_resp}); end
    @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({pmem_write, pmem_read, empty, count} !== {3'b001, 3'd0}) begin n_fail++; $display("FAIL rstmid_after: write/read/empty=%b count=%0d required 001/0", {pmem_write, pmem_read, empty}, count); end
    @(negedge clk);
    n_chk++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: pmem_write got %b required 0", pmem_write); end
    dl_addr.delete(); dl_data.delete();
    write_line(32'h600, mkd(32'hC6));
    release_up();
    drain_all("rstmid");
    n_chk++; if ((dl_addr.size() == 1 ? dl_addr[0] : '0) !== 32'h600) begin n_fail++; $display("FAIL rstmid_discard: %0d drains, required only 600", dl_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_coalesce();
    test_read_hit();
    test_read_miss();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
